// File: rtl/decode_if.sv
// rtl/decode_if.sv - instruction word in, data-memory and register-write controls out
interface decode_if;
   logic [31:0] instr;
   logic        MemWrite;
   logic [3:0]  DMLOp;
   logic [3:0]  DMSOp;
   logic        load;
   logic        store;
   logic        RegWrite;
   logic [1:0]  WRSel;
   logic        ri;
   logic        prev_load;

   modport master (
      output instr,
      input  MemWrite, DMLOp, DMSOp, load, store, RegWrite, WRSel, ri, prev_load
   );

   modport slave (
      input  instr,
      output MemWrite, DMLOp, DMSOp, load, store, RegWrite, WRSel, ri, prev_load
   );
endinterface

// File: rtl/decode.sv
// rtl/decode.sv - M-stage MIPS decoder: memory sub-ops, register write control, registered load flag
module decode (
   input  logic      clk,
   input  logic      reset,
   decode_if.slave   bus
);
   logic [5:0] op;
   logic [5:0] funct;
   logic [4:0] rs;
   logic [3:0] dml_op;
   logic [3:0] dms_op;
   logic       is_load;
   logic       is_store;
   logic       reg_write;
   logic [1:0] wr_sel;
   logic       ri;
   logic       prev_load_q;

   assign op    = bus.instr[31:26];
   assign funct = bus.instr[5:0];
   assign rs    = bus.instr[25:21];

   // Unrecognised encodings only raise ri; all other outputs keep their zero defaults.
   always_comb begin
      dml_op    = 4'd0;
      dms_op    = 4'd0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      reg_write = 1'b0;
      wr_sel    = 2'd0;
      ri        = 1'b0;
      case (op)
         6'b100011: begin is_load = 1'b1; dml_op = 4'd1; end
         6'b100000: begin is_load = 1'b1; dml_op = 4'd2; end
         6'b100100: begin is_load = 1'b1; dml_op = 4'd3; end
         6'b100001: begin is_load = 1'b1; dml_op = 4'd4; end
         6'b100101: begin is_load = 1'b1; dml_op = 4'd5; end
         6'b101011: begin is_store = 1'b1; dms_op = 4'd1; end
         6'b101000: begin is_store = 1'b1; dms_op = 4'd2; end
         6'b101001: begin is_store = 1'b1; dms_op = 4'd3; end
         6'b000000: begin
            case (funct)
               6'b100000, 6'b100001, 6'b100010, 6'b100011,
               6'b100100, 6'b100101, 6'b100110, 6'b100111,
               6'b101010, 6'b101011, 6'b000000, 6'b000010,
               6'b000011, 6'b000100, 6'b000110, 6'b000111,
               6'b010000, 6'b010010, 6'b001001: begin
                  reg_write = 1'b1;
                  wr_sel    = 2'd1;
               end
               6'b001000, 6'b010001, 6'b010011, 6'b011000,
               6'b011001, 6'b011010, 6'b011011: ;
               default: ri = 1'b1;
            endcase
         end
         6'b001000, 6'b001001, 6'b001100, 6'b001101,
         6'b001110, 6'b001111, 6'b001010, 6'b001011: reg_write = 1'b1;
         6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000010: ;
         6'b000011: begin
            reg_write = 1'b1;
            wr_sel    = 2'd2;
         end
         6'b010000: begin
            if (bus.instr == 32'h4200_0018) begin
               ri = 1'b0;
            end else if (rs == 5'b00000) begin
               reg_write = 1'b1;
            end else if (rs != 5'b00100) begin
               ri = 1'b1;
            end
         end
         default: ri = 1'b1;
      endcase
      if (is_load) reg_write = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) prev_load_q <= 1'b0;
      else        prev_load_q <= is_load;
   end

   assign bus.MemWrite  = is_store;
   assign bus.DMLOp     = dml_op;
   assign bus.DMSOp     = dms_op;
   assign bus.load      = is_load;
   assign bus.store     = is_store;
   assign bus.RegWrite  = reg_write;
   assign bus.WRSel     = wr_sel;
   assign bus.ri        = ri;
   assign bus.prev_load = prev_load_q;
endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - scoreboard bench for decode against a table-driven reference model
module tb_decode;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   decode_if dif ();
   decode dut (.clk(clk), .reset(reset), .bus(dif));

   typedef struct packed {
      logic       memwrite;
      logic [3:0] dmlop;
      logic [3:0] dmsop;
      logic       load;
      logic       store;
      logic       regwrite;
      logic [1:0] wrsel;
      logic       ri;
      logic       prev;
      logic [31:0] word;
   } exp_t;

   int n_checks = 0;
   int n_fail   = 0;

   int  ld_map[int];
   int  st_map[int];
   bit  rw_fn[int];
   bit  nw_fn[int];
   bit  ialu_op[int];
   bit  nw_op[int];
   int  known_ops[$];

   exp_t sb_q[$];
   logic sb_valid = 1'b0;
   logic last_load = 1'b0;

   task automatic check(input string name, input int act, input int exp_v, input logic [31:0] w);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (instr %08h)", name, act, exp_v, w);
      end
   endtask

   function automatic exp_t model(input logic [31:0] w);
      exp_t e;
      int op, fn, rs;
      e = '0;
      e.word = w;
      op = int'(w[31:26]);
      fn = int'(w[5:0]);
      rs = int'(w[25:21]);
      if (ld_map.exists(op)) begin
         e.load = 1; e.dmlop = 4'(ld_map[op]); e.regwrite = 1;
      end else if (st_map.exists(op)) begin
         e.store = 1; e.memwrite = 1; e.dmsop = 4'(st_map[op]);
      end else if (op == 0) begin
         if (rw_fn.exists(fn)) begin e.regwrite = 1; e.wrsel = 2'd1; end
         else if (!nw_fn.exists(fn)) e.ri = 1;
      end else if (ialu_op.exists(op)) begin
         e.regwrite = 1;
      end else if (nw_op.exists(op)) begin
         e.regwrite = 0;
      end else if (op == 3) begin
         e.regwrite = 1; e.wrsel = 2'd2;
      end else if (op == 16) begin
         if (w == 32'h4200_0018) e.ri = 0;
         else if (rs == 0) e.regwrite = 1;
         else if (rs != 4) e.ri = 1;
      end else begin
         e.ri = 1;
      end
      return e;
   endfunction

   task automatic apply(input logic [31:0] w);
      exp_t e;
      @(posedge clk);
      #1;
      dif.instr = w;
      e = model(w);
      e.prev = last_load;
      last_load = e.load;
      sb_q.push_back(e);
      sb_valid = 1'b1;
   endtask

   // Monitor: one scoreboard entry is consumed per negedge while stimulus is live.
   always @(negedge clk) begin
      if (sb_valid) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0, dif.instr);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("instr_seen", int'(dif.instr), int'(e.word), e.word);
            check("MemWrite", int'(dif.MemWrite), int'(e.memwrite), e.word);
            check("DMLOp", int'(dif.DMLOp), int'(e.dmlop), e.word);
            check("DMSOp", int'(dif.DMSOp), int'(e.dmsop), e.word);
            check("load", int'(dif.load), int'(e.load), e.word);
            check("store", int'(dif.store), int'(e.store), e.word);
            check("RegWrite", int'(dif.RegWrite), int'(e.regwrite), e.word);
            check("WRSel", int'(dif.WRSel), int'(e.wrsel), e.word);
            check("ri", int'(dif.ri), int'(e.ri), e.word);
            check("prev_load", int'(dif.prev_load), int'(e.prev), e.word);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] directed [16] = '{
      32'h8C01_0004, 32'hA022_0003, 32'hA422_0002, 32'h8022_0000,
      32'h9022_0001, 32'h8422_0002, 32'h9422_0003, 32'h0C00_0010,
      32'h0022_1820, 32'h0000_0000, 32'hFC00_0000, 32'h0022_183F,
      32'h4000_6000, 32'h4080_6000, 32'h4200_0018, 32'hAC22_0000
   };

   initial begin
      logic [31:0] w;
      ld_map[6'h23] = 1; ld_map[6'h20] = 2; ld_map[6'h24] = 3;
      ld_map[6'h21] = 4; ld_map[6'h25] = 5;
      st_map[6'h2B] = 1; st_map[6'h28] = 2; st_map[6'h29] = 3;
      foreach (rw_fn[k]) rw_fn.delete(k);
      for (int i = 'h20; i <= 'h27; i++) rw_fn[i] = 1;
      rw_fn['h2A] = 1; rw_fn['h2B] = 1; rw_fn['h00] = 1; rw_fn['h02] = 1;
      rw_fn['h03] = 1; rw_fn['h04] = 1; rw_fn['h06] = 1; rw_fn['h07] = 1;
      rw_fn['h10] = 1; rw_fn['h12] = 1; rw_fn['h09] = 1;
      nw_fn['h08] = 1; nw_fn['h11] = 1; nw_fn['h13] = 1;
      for (int i = 'h18; i <= 'h1B; i++) nw_fn[i] = 1;
      for (int i = 'h08; i <= 'h0F; i++) ialu_op[i] = 1;
      nw_op['h04] = 1; nw_op['h05] = 1; nw_op['h06] = 1; nw_op['h07] = 1; nw_op['h02] = 1;
      known_ops = '{'h23, 'h20, 'h24, 'h21, 'h25, 'h2B, 'h28, 'h29, 'h08, 'h09,
                    'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F, 'h04, 'h05, 'h06, 'h07,
                    'h02, 'h03, 'h00, 'h10};

      reset = 1'b0;
      dif.instr = 32'h8C01_0004;
      repeat (2) @(posedge clk);
      #1;
      check("reset_prev_load", int'(dif.prev_load), 0, dif.instr);
      dif.instr = 32'h0;
      @(negedge clk);
      reset = 1'b1;

      foreach (directed[i]) apply(directed[i]);
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: w = $urandom;
            1: begin
               w = $urandom;
               w[31:26] = 6'(known_ops[$urandom_range(0, known_ops.size() - 1)]);
            end
            2: begin
               w = $urandom;
               w[31:26] = 6'd0;
            end
            default: begin
               w = $urandom;
               w[31:26] = 6'b010000;
               case ($urandom_range(0, 3))
                  0: w[25:21] = 5'd0;
                  1: w[25:21] = 5'd4;
                  2: w = 32'h4200_0018;
                  default: ;
               endcase
            end
         endcase
         apply(w);
      end
      @(negedge clk);
      #1;
      sb_valid = 1'b0;
      check("sb_drained", sb_q.size(), 0, dif.instr);

      dif.instr = 32'h8C01_0004;
      @(posedge clk);
      #1;
      check("prev_load_after_lw", int'(dif.prev_load), 1, dif.instr);
      #2;
      reset = 1'b0;
      #1;
      check("prev_load_async_clear", int'(dif.prev_load), 0, dif.instr);
      check("comb_during_reset", int'(dif.DMLOp), 1, dif.instr);
      dif.instr = 32'hAC22_0000;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("prev_load_after_sw", int'(dif.prev_load), 0, dif.instr);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
